dmem_ctrl: RTL

Multi-cycle data-memory stage for the RISC-V core. It sits directly downstream of the control unit and consumes its `DMWr` and `DMCtrl` outputs together with the ALU result (address) and `rs2` data. It performs byte/half/word loads and stores against an internal word-wide synchronous RAM, using read-modify-write for sub-word stores. It holds the core with `Stall` until each access completes.

---
 rtl/dmem_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory stage: byte/half/word loads and stores against an
// internal synchronous word RAM, with read-modify-write for sub-word stores.
module dmem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Req,
    input  logic        DMWr,
    input  logic [2:0]  DMCtrl,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    output logic [31:0] DataRd,
    output logic        Stall,
    output logic        Done,
    output logic        Fault
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_t;

    state_t      state;
    logic        wr_q;
    logic [2:0]  ctrl_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merged_q;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] ram_q;
    logic        ram_we;
    logic        ram_re;
    logic [AW-1:0] ram_widx;
    logic [AW-1:0] ram_ridx;
    logic [31:0] ram_wdata;

    logic        in_illegal;
    logic        in_sw;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{Address[31:2+AW], addr_q[31:2+AW]};

    function automatic logic illegal_access(input logic [2:0] c, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        case (c)
            3'b011, 3'b110, 3'b111: bad = 1'b1;
            3'b001, 3'b101:         bad = a[0];
            3'b010:                 bad = (a != 2'b00);
            default:                bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] format_load(input logic [31:0] w, input logic [2:0] c,
                                                input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (c)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'h000000, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'h0000, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] w, input logic [31:0] d,
                                                input logic [2:0] c, input logic [1:0] a);
        logic [31:0] m;
        m = w;
        if (c[1:0] == 2'b00) begin
            case (a)
                2'd0:    m[7:0]   = d[7:0];
                2'd1:    m[15:8]  = d[7:0];
                2'd2:    m[23:16] = d[7:0];
                default: m[31:24] = d[7:0];
            endcase
        end else if (a[1]) begin
            m[31:16] = d[15:0];
        end else begin
            m[15:0] = d[15:0];
        end
        return m;
    endfunction

    assign in_illegal = illegal_access(DMCtrl, Address[1:0]);
    assign in_sw      = DMWr && (DMCtrl[1:0] == 2'b10);

    // Full-word stores write straight from the inputs at accept; sub-word
    // stores write the merged word from WR. Everything else reads.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_widx  = addr_q[2 +: AW];
        ram_wdata = merged_q;
        ram_ridx  = Address[2 +: AW];
        case (state)
            IDLE: begin
                if (Req && !in_illegal) begin
                    if (in_sw) begin
                        ram_we    = 1'b1;
                        ram_widx  = Address[2 +: AW];
                        ram_wdata = DataWr;
                    end else begin
                        ram_re = 1'b1;
                    end
                end
            end
            WR:      ram_we = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            mem[ram_widx] <= ram_wdata;
        end
        if (ram_re) begin
            ram_q <= mem[ram_ridx];
        end
    end

    always_comb begin
        Stall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    Stall = Req;
                RD, WR:  Stall = 1'b1;
                default: Stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            DataRd   <= '0;
            Done     <= 1'b0;
            Fault    <= 1'b0;
            wr_q     <= 1'b0;
            ctrl_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
        end else begin
            Done  <= 1'b0;
            Fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (Req) begin
                        wr_q    <= DMWr;
                        ctrl_q  <= DMCtrl;
                        addr_q  <= Address;
                        wdata_q <= DataWr;
                        if (in_illegal) begin
                            state <= RESP;
                            Done  <= 1'b1;
                            Fault <= 1'b1;
                        end else if (in_sw) begin
                            state <= RESP;
                            Done  <= 1'b1;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (!wr_q) begin
                        DataRd <= format_load(ram_q, ctrl_q, addr_q[1:0]);
                        state  <= RESP;
                        Done   <= 1'b1;
                    end else begin
                        merged_q <= merge_store(ram_q, wdata_q, ctrl_q, addr_q[1:0]);
                        state    <= WR;
                    end
                end
                WR: begin
                    state <= RESP;
                    Done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
